// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one alu between two requesters with round-robin arbitration and a
// single registered result slot.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   reqN_valid/ready             requester N operation handshake (ready is combinational)
//   reqN_sel, reqN_a, reqN_b     requester N opcode and operands
//   rspN_valid/ready             requester N result handshake
//   rsp_data, rsp_err            held result (shared by both response ports) and error flag
//
// The file also holds the alu used by the arbiter. Its ports:
//   sel_i, a_i, b_i              opcode and operands
//   res_o, err_o                 combinational result, undefined-opcode flag
//
// Opcode map (codes not listed pass operand a through):
//   00000 ADD    00001 SUB   00010 SLL   00011 SLT   00100 SLTU
//   00101 XOR    00110 SRL   00111 SRA   01000 OR    01001 AND
//   11000 ADDIW  11001 SLLIW 11010 SRLIW 11011 SRAIW 11100 SUBW
//   11101, 11110 undefined: result zero, err high
// Word ops zero the upper DWIDTH-32 bits; DWIDTH must be at least 32.

module alu #(
    parameter int unsigned DWIDTH = 64
) (
    input  logic [4:0]        sel_i,
    input  logic [DWIDTH-1:0] a_i,
    input  logic [DWIDTH-1:0] b_i,
    output logic [DWIDTH-1:0] res_o,
    output logic              err_o
);
    localparam int unsigned ShW = $clog2(DWIDTH);

    localparam logic [4:0] OpAdd   = 5'b00000;
    localparam logic [4:0] OpSub   = 5'b00001;
    localparam logic [4:0] OpSll   = 5'b00010;
    localparam logic [4:0] OpSlt   = 5'b00011;
    localparam logic [4:0] OpSltu  = 5'b00100;
    localparam logic [4:0] OpXor   = 5'b00101;
    localparam logic [4:0] OpSrl   = 5'b00110;
    localparam logic [4:0] OpSra   = 5'b00111;
    localparam logic [4:0] OpOr    = 5'b01000;
    localparam logic [4:0] OpAnd   = 5'b01001;
    localparam logic [4:0] OpAddw  = 5'b11000;
    localparam logic [4:0] OpSllw  = 5'b11001;
    localparam logic [4:0] OpSrlw  = 5'b11010;
    localparam logic [4:0] OpSraw  = 5'b11011;
    localparam logic [4:0] OpSubw  = 5'b11100;
    localparam logic [4:0] OpBad0  = 5'b11101;
    localparam logic [4:0] OpBad1  = 5'b11110;

    logic [ShW-1:0] shamt;
    assign shamt = b_i[ShW-1:0];

    // res_o defaults to zero so word ops never carry stale upper bits.
    always_comb begin
        res_o = '0;
        err_o = 1'b0;
        case (sel_i)
            OpAdd:  res_o = a_i + b_i;
            OpSub:  res_o = a_i - b_i;
            OpSll:  res_o = a_i << shamt;
            OpSlt:  res_o[0] = $signed(a_i) < $signed(b_i);
            OpSltu: res_o[0] = a_i < b_i;
            OpXor:  res_o = a_i ^ b_i;
            OpSrl:  res_o = a_i >> shamt;
            OpSra:  res_o = $signed(a_i) >>> shamt;
            OpOr:   res_o = a_i | b_i;
            OpAnd:  res_o = a_i & b_i;
            OpAddw: res_o[31:0] = a_i[31:0] + b_i[31:0];
            OpSllw: res_o[31:0] = a_i[31:0] << b_i[4:0];
            OpSrlw: res_o[31:0] = a_i[31:0] >> b_i[4:0];
            OpSraw: res_o[31:0] = $signed(a_i[31:0]) >>> b_i[4:0];
            OpSubw: res_o[31:0] = a_i[31:0] - b_i[31:0];
            OpBad0, OpBad1: err_o = 1'b1;
            default: res_o = a_i;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int unsigned DWIDTH = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [4:0]        req0_sel,
    input  logic [DWIDTH-1:0] req0_a,
    input  logic [DWIDTH-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [4:0]        req1_sel,
    input  logic [DWIDTH-1:0] req1_a,
    input  logic [DWIDTH-1:0] req1_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DWIDTH-1:0] rsp_data,
    output logic              rsp_err
);
    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;   // requester whose result is held
    logic              last_q, last_d;     // requester granted most recently
    logic [DWIDTH-1:0] data_q, data_d;
    logic              err_q, err_d;

    logic              owner_ready, accept, grant0, grant1;
    logic [4:0]        alu_sel;
    logic [DWIDTH-1:0] alu_a, alu_b, alu_res;
    logic              alu_err;

    // Only the owner's rsp_ready frees the slot; the other port's is ignored.
    assign owner_ready = owner_q ? rsp1_ready : rsp0_ready;
    // Gating with rst_n keeps ready low throughout reset.
    assign accept = rst_n && ((state_q == StIdle) || owner_ready);

    // On a tie the requester not granted last wins.
    assign grant0 = accept && req0_valid && (!req1_valid || last_q);
    assign grant1 = accept && req1_valid && (!req0_valid || !last_q);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign alu_sel = grant1 ? req1_sel : req0_sel;
    assign alu_a   = grant1 ? req1_a   : req0_a;
    assign alu_b   = grant1 ? req1_b   : req0_b;

    alu #(
        .DWIDTH(DWIDTH)
    ) u_alu (
        .sel_i(alu_sel),
        .a_i  (alu_a),
        .b_i  (alu_b),
        .res_o(alu_res),
        .err_o(alu_err)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        data_d  = data_q;
        err_d   = err_q;
        if (grant0 || grant1) begin
            state_d = StHold;
            owner_d = grant1;
            last_d  = grant1;
            data_d  = alu_res;
            err_d   = alu_err;
        end else if ((state_q == StHold) && owner_ready) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign rsp0_valid = (state_q == StHold) && !owner_q;
    assign rsp1_valid = (state_q == StHold) && owner_q;
    assign rsp_data   = data_q;
    assign rsp_err    = err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, contention and reset-in-hold
// sequences, then randomized traffic against a transaction-level reference model.
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [4:0]  req0_sel, req1_sel;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [63:0] rsp_data;
    logic        rsp_err;

    int errors = 0;
    int checks = 0;

    alu_arbiter #(
        .DWIDTH(64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_sel  (req0_sel),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_sel  (req1_sel),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .rsp0_valid(rsp0_valid),
        .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid),
        .rsp1_ready(rsp1_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference alu: {err, data} from the opcode table.
    function automatic logic [64:0] ref_alu(input logic [4:0] sel, input logic [63:0] a,
                                            input logic [63:0] b);
        logic [63:0] r;
        logic [31:0] w;
        logic        e;
        r = 64'd0;
        w = 32'd0;
        e = 1'b0;
        case (sel)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  r = a << b[5:0];
            5'd3:  r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            5'd4:  r = (a < b) ? 64'd1 : 64'd0;
            5'd5:  r = a ^ b;
            5'd6:  r = a >> b[5:0];
            5'd7:  r = $signed(a) >>> b[5:0];
            5'd8:  r = a | b;
            5'd9:  r = a & b;
            5'd24: begin w = a[31:0] + b[31:0]; r = {32'd0, w}; end
            5'd25: begin w = a[31:0] << b[4:0]; r = {32'd0, w}; end
            5'd26: begin w = a[31:0] >> b[4:0]; r = {32'd0, w}; end
            5'd27: begin w = $signed(a[31:0]) >>> b[4:0]; r = {32'd0, w}; end
            5'd28: begin w = a[31:0] - b[31:0]; r = {32'd0, w}; end
            5'd29, 5'd30: begin r = 64'd0; e = 1'b1; end
            default: r = a;
        endcase
        return {e, r};
    endfunction

    function automatic logic [63:0] rnd_operand();
        logic [63:0] v;
        case ($urandom_range(0, 3))
            0: v = {$urandom, $urandom};
            1: v = 64'hFFFF_FFFF_FFFF_FFFF;
            2: v = 64'($urandom_range(0, 70));
            default: v = {32'd0, $urandom};
        endcase
        return v;
    endfunction

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; req0_sel = 0; req1_sel = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        rsp0_ready = 0; rsp1_ready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    typedef struct {
        logic        v0, v1;
        logic [4:0]  s0;
        logic [63:0] a0, b0;
        logic [4:0]  s1;
        logic [63:0] a1, b1;
        logic        rr0, rr1;
        logic        er0, er1;   // expected req ready this cycle
        logic        ev0, ev1;   // expected rsp valid after the edge
        logic [63:0] ed;
        logic        ee;
    } vec_t;

    vec_t vecs[12];

    // Reference model state
    bit          m_held, m_owner, m_last;
    logic [63:0] m_data;
    logic        m_err;

    initial begin
        logic [64:0] r;
        bit acc, g0, g1;

        // Single op, backpressure, word op after stale data, undefined code, idle hold.
        vecs[0]  = '{1, 0, 5'd0,  64'd5, 64'd7, 5'd0, 64'd0,  64'd0, 1, 0, 1, 0, 1, 0, 64'd12, 0};
        vecs[1]  = '{0, 1, 5'd0,  64'd0, 64'd0, 5'd1, 64'd10, 64'd3, 1, 0, 0, 1, 0, 1, 64'd7,  0};
        vecs[2]  = '{1, 1, 5'd0,  64'd1, 64'd1, 5'd0, 64'd1,  64'd1, 1, 0, 0, 0, 0, 1, 64'd7,  0};
        vecs[3]  = vecs[2];
        vecs[4]  = vecs[2];
        vecs[5]  = '{1, 1, 5'd0,  64'd1, 64'd1, 5'd0, 64'd1,  64'd1, 1, 1, 1, 0, 1, 0, 64'd2,  0};
        vecs[6]  = '{1, 0, 5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 5'd0, 64'd0, 64'd0,
                     1, 0, 1, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0};
        vecs[7]  = '{1, 0, 5'd24, 64'h7FFF_FFFF, 64'd1, 5'd0, 64'd0, 64'd0,
                     1, 0, 1, 0, 1, 0, 64'h0000_0000_8000_0000, 0};
        vecs[8]  = '{1, 0, 5'd29, 64'd1, 64'd1, 5'd0, 64'd0,  64'd0, 1, 0, 1, 0, 1, 0, 64'd0,  1};
        vecs[9]  = '{1, 0, 5'd0,  64'd1, 64'd1, 5'd0, 64'd0,  64'd0, 1, 0, 1, 0, 1, 0, 64'd2,  0};
        vecs[10] = '{0, 0, 5'd0,  64'd0, 64'd0, 5'd0, 64'd0,  64'd0, 1, 0, 0, 0, 0, 0, 64'd2,  0};
        vecs[11] = '{0, 0, 5'd0,  64'd0, 64'd0, 5'd0, 64'd0,  64'd0, 0, 0, 0, 0, 0, 0, 64'd2,  0};

        idle_inputs();
        rst_n = 0;
        #12;
        chk("reset rsp0_valid", 64'(rsp0_valid), 64'd0);
        chk("reset rsp1_valid", 64'(rsp1_valid), 64'd0);
        chk("reset rsp_data", rsp_data, 64'd0);
        chk("reset rsp_err", 64'(rsp_err), 64'd0);
        req0_valid = 1; req1_valid = 1;
        #1;
        chk("reset req0_ready", 64'(req0_ready), 64'd0);
        chk("reset req1_ready", 64'(req1_ready), 64'd0);
        do_reset();

        for (int i = 0; i < 12; i++) begin
            req0_valid = vecs[i].v0; req0_sel = vecs[i].s0;
            req0_a = vecs[i].a0; req0_b = vecs[i].b0;
            req1_valid = vecs[i].v1; req1_sel = vecs[i].s1;
            req1_a = vecs[i].a1; req1_b = vecs[i].b1;
            rsp0_ready = vecs[i].rr0; rsp1_ready = vecs[i].rr1;
            #1;
            chk($sformatf("vec%0d req0_ready", i), 64'(req0_ready), 64'(vecs[i].er0));
            chk($sformatf("vec%0d req1_ready", i), 64'(req1_ready), 64'(vecs[i].er1));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d rsp0_valid", i), 64'(rsp0_valid), 64'(vecs[i].ev0));
            chk($sformatf("vec%0d rsp1_valid", i), 64'(rsp1_valid), 64'(vecs[i].ev1));
            chk($sformatf("vec%0d rsp_data", i), rsp_data, vecs[i].ed);
            chk($sformatf("vec%0d rsp_err", i), 64'(rsp_err), 64'(vecs[i].ee));
            @(negedge clk);
        end

        // Contention: both requesters valid every cycle, grants alternate starting at 0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1; req1_valid = 1; req0_sel = 0; req1_sel = 0;
            req0_a = 64'(i); req0_b = 64'd100; req1_a = 64'(i); req1_b = 64'd200;
            rsp0_ready = 1; rsp1_ready = 1;
            #1;
            chk($sformatf("rr%0d req0_ready", i), 64'(req0_ready), 64'(i % 2 == 0));
            chk($sformatf("rr%0d req1_ready", i), 64'(req1_ready), 64'(i % 2 == 1));
            @(posedge clk);
            #1;
            chk($sformatf("rr%0d rsp0_valid", i), 64'(rsp0_valid), 64'(i % 2 == 0));
            chk($sformatf("rr%0d rsp1_valid", i), 64'(rsp1_valid), 64'(i % 2 == 1));
            chk($sformatf("rr%0d rsp_data", i), rsp_data, 64'(i + ((i % 2 == 0) ? 100 : 200)));
            @(negedge clk);
        end

        // Reset while holding requester 1's result, asserted away from any clock edge.
        do_reset();
        idle_inputs();
        req1_valid = 1; req1_sel = 5'd1; req1_a = 64'd10; req1_b = 64'd3;
        @(posedge clk);
        #1;
        chk("rst_hold rsp1_valid before", 64'(rsp1_valid), 64'd1);
        @(negedge clk);
        req0_valid = 1; req1_valid = 1; rsp1_ready = 0;
        #2;
        rst_n = 0;
        #1;
        chk("rst_hold rsp1_valid", 64'(rsp1_valid), 64'd0);
        chk("rst_hold rsp_data", rsp_data, 64'd0);
        chk("rst_hold req0_ready", 64'(req0_ready), 64'd0);
        chk("rst_hold req1_ready", 64'(req1_ready), 64'd0);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("rst_rel rsp1_valid", 64'(rsp1_valid), 64'd0);
        chk("rst_rel req0_ready", 64'(req0_ready), 64'd1);
        chk("rst_rel req1_ready", 64'(req1_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_rel rsp0_valid", 64'(rsp0_valid), 64'd1);

        // Randomized traffic against the transaction-level model.
        do_reset();
        m_held = 0; m_owner = 0; m_last = 1; m_data = 0; m_err = 0;
        for (int c = 0; c < 500; c++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_sel = 5'($urandom_range(0, 31));
            req1_sel = 5'($urandom_range(0, 31));
            req0_a = rnd_operand(); req0_b = rnd_operand();
            req1_a = rnd_operand(); req1_b = rnd_operand();
            rsp0_ready = ($urandom_range(0, 2) != 0);
            rsp1_ready = ($urandom_range(0, 2) != 0);
            #1;
            chk("rand rsp0_valid", 64'(rsp0_valid), 64'(m_held && !m_owner));
            chk("rand rsp1_valid", 64'(rsp1_valid), 64'(m_held && m_owner));
            if (m_held) begin
                chk("rand rsp_data", rsp_data, m_data);
                chk("rand rsp_err", 64'(rsp_err), 64'(m_err));
            end
            acc = !m_held || (m_owner ? rsp1_ready : rsp0_ready);
            g0 = 0; g1 = 0;
            if (acc && req0_valid && req1_valid) begin
                if (m_last) g0 = 1; else g1 = 1;
            end else if (acc) begin
                g0 = req0_valid; g1 = req1_valid;
            end
            chk("rand req0_ready", 64'(req0_ready), 64'(g0));
            chk("rand req1_ready", 64'(req1_ready), 64'(g1));
            @(posedge clk);
            if (g0 || g1) begin
                r = g1 ? ref_alu(req1_sel, req1_a, req1_b) : ref_alu(req0_sel, req0_a, req0_b);
                m_held = 1; m_owner = g1; m_last = g1;
                m_data = r[63:0]; m_err = r[64];
            end else if (acc) begin
                m_held = 0;
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DWIDTH, default 64, operand/result width passed to the shared alu instance.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1 each  requester N presents an operation.
REQ-005 req0_ready / req1_ready  output  1 each  operation of requester N accepted this cycle.
REQ-006 req0_sel / req1_sel  input  5 each  alu operation code of requester N.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  DWIDTH each  operands of requester N.
REQ-008 rsp0_valid / rsp1_valid  output  1 each  result for requester N is held.
REQ-009 rsp0_ready / rsp1_ready  input  1 each  requester N consumes its result.
REQ-010 rsp_data  output  DWIDTH  registered alu result, shared by both response ports.
REQ-011 rsp_err  output  1  held result came from an undefined operation code.

Function
REQ-012 Block shall contain exactly one alu instance, sharing it between requester 0 and requester 1.
REQ-013 States: IDLE (no result held), HOLD (result held, rsp_valid of owner high).
REQ-014 Accept condition: state IDLE, or state HOLD with owner's rsp_ready high in same cycle.
REQ-015 req_ready shall be combinational, high for at most one requester per cycle, and only under the accept condition.
REQ-016 Arbitration: if only one req_valid high, grant it; if both high, grant the requester not granted last (round-robin); last-grant pointer resets to 1 so requester 0 wins first tie.
REQ-017 On grant, granted sel/a/b drive the alu; the alu output is captured into rsp_data at that edge, with latency exactly one cycle from acceptance to rsp_valid.
REQ-018 After a grant, state HOLD, owner recorded; only the owner's rsp_valid is high.
REQ-019 rsp_data, rsp_err and owner shall remain stable while in HOLD until the owner's rsp_ready is sampled high.
REQ-020 HOLD with owner rsp_ready high and no grant: return to IDLE, rsp_valid low next cycle.
REQ-021 HOLD with owner rsp_ready high and new grant: stay in HOLD with new result/owner, allowing back-to-back one operation per cycle.
REQ-022 rsp_ready of the non-owner shall be ignored.
REQ-023 Undefined codes 5'b11101 and 5'b11110: rsp_data forced to zero, rsp_err high; otherwise rsp_err low.
REQ-024 For ADDIW/SLLIW/SRLIW/SRAIW (5'b11000-5'b11011), upper DWIDTH-32 bits of rsp_data shall be zero, never a previous value.
REQ-025 When in IDLE with no req_valid, no state, pointer or rsp_data change.

Reset
REQ-026 rst_n low: state IDLE, rsp0_valid = rsp1_valid = 0, rsp_data = 0, rsp_err = 0, last-grant pointer = 1, immediately and independent of clk.
REQ-027 req_ready outputs shall be low while rst_n is low.
REQ-028 Reset asserted during HOLD shall discard the held result; no response delivered after release.
REQ-029 First grant allowed on first rising edge with rst_n high.

Verification
REQ-030 Single op: req0 sel=5'b00000, a=5, b=7, rsp0_ready=1 -> req0_ready high same cycle, next cycle rsp0_valid=1, rsp_data=12, rsp_err=0.
REQ-031 Contention: both valid every cycle, both rsp_ready=1 -> grants alternate 0,1,0,1; 4 results in 4 consecutive cycles after first.
REQ-032 Backpressure: req1 SUB a=10 b=3, rsp1_ready=0 for 3 cycles -> rsp1_valid and rsp_data=7 stable, req0_ready and req1_ready low until rsp1_ready high.
REQ-033 Word op with stale data: ADD a=all ones b=0, then ADDIW a=32'h7FFF_FFFF b=1 -> second rsp_data=64'h0000_0000_8000_0000.
REQ-034 Undefined code 5'b11101 a=1 b=1 -> rsp_data=0, rsp_err=1; following ADD 1+1 -> rsp_data=2, rsp_err=0.
REQ-035 Reset in HOLD: assert rst_n low mid-cycle -> rsp valids and rsp_data drop to 0 without clock edge; after release both valid -> requester 0 granted first.
